// File: rtl/rv_pkg.sv
// Shared commit-path types: the buffered commit entry and the helper that
// blanks an invalid slot or suppresses the write of an x0 destination.
package rv_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int COMMIT_XLEN = 32;

  typedef struct packed {
    logic [COMMIT_XLEN-1:0] pc;
    logic [REG_ADDR_W-1:0]  rd;
    logic                   we;
    logic [COMMIT_XLEN-1:0] data;
  } commit_entry_t;

  function automatic commit_entry_t force_fields(input commit_entry_t e, input logic valid);
    commit_entry_t r;
    r = e;
    if (!valid) r = '0;
    else if (e.rd == '0) r.we = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/commit_fifo_2w.sv
// Circular buffer of commit entries accepting 0..2 writes and retiring 0..2
// reads per cycle; the two oldest entries are always visible at the head.
module commit_fifo_2w
  import rv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic [1:0]               push_cnt,
  input  commit_entry_t            push0,
  input  commit_entry_t            push1,
  input  logic [1:0]               pop_cnt,
  output commit_entry_t            head0,
  output commit_entry_t            head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  commit_entry_t   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr_p1;
  logic [PW-1:0]   rd_ptr_p1;

  // Pointers are exactly PW bits wide so the mod-DEPTH wrap is free.
  assign wr_ptr_p1 = wr_ptr + PW'(1);
  assign rd_ptr_p1 = rd_ptr + PW'(1);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr]    <= push0;
    if (push_cnt == 2'd2) mem[wr_ptr_p1] <= push1;
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr_p1];

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
    (int'(count) + int'(push_cnt) - int'(pop_cnt)) <= DEPTH);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst_i)
    int'(pop_cnt) <= int'(count));
`endif

endmodule

// File: rtl/wb_order_restorer.sv
// Restores program order of a (possibly decode-swapped) writeback pair and
// presents up to two in-order commits per cycle. Optional RETIRE_CNT_EN adds retired_cnt_o.
module wb_order_restorer
  import rv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    order_change_i,
  input  logic                    l1_valid_i,
  input  logic [XLEN-1:0]         l1_pc_i,
  input  logic [REG_ADDR_W-1:0]   l1_rd_i,
  input  logic                    l1_we_i,
  input  logic [XLEN-1:0]         l1_data_i,
  input  logic                    l2_valid_i,
  input  logic [XLEN-1:0]         l2_pc_i,
  input  logic [REG_ADDR_W-1:0]   l2_rd_i,
  input  logic                    l2_we_i,
  input  logic [XLEN-1:0]         l2_data_i,
  output logic                    c0_valid_o,
  output logic [XLEN-1:0]         c0_pc_o,
  output logic [REG_ADDR_W-1:0]   c0_rd_o,
  output logic                    c0_we_o,
  output logic [XLEN-1:0]         c0_data_o,
  output logic                    c1_valid_o,
  output logic [XLEN-1:0]         c1_pc_o,
  output logic [REG_ADDR_W-1:0]   c1_rd_o,
  output logic                    c1_we_o,
  output logic [XLEN-1:0]         c1_data_o,
  input  logic                    commit_ready_i,
  output logic [$clog2(DEPTH):0]  occupancy_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0]             retired_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (XLEN != COMMIT_XLEN) begin : g_xlen_check
    $error("wb_order_restorer: XLEN must equal rv_pkg::COMMIT_XLEN");
  end

  // Handshake: a pair transfers on the rising edge where in_valid_i & in_ready_o;
  // every commit presented on c0/c1 is consumed on the edge where commit_ready_i=1.
  logic [CW-1:0]  count;
  logic [1:0]     push_cnt;
  logic [1:0]     pop_cnt;
  logic           accept;
  logic           first_v;
  logic           second_v;
  logic           c0_valid;
  logic           c1_valid;
  commit_entry_t  lane1, lane2, first, second;
  commit_entry_t  push0, push1, head0, head1, c0, c1;

  // Ready looks only at the registered count, so a same-cycle pop never raises it.
  assign in_ready_o = (count <= CW'(DEPTH - 2));
  assign accept     = in_valid_i & in_ready_o;

  assign lane1 = '{pc: l1_pc_i, rd: l1_rd_i, we: l1_we_i, data: l1_data_i};
  assign lane2 = '{pc: l2_pc_i, rd: l2_rd_i, we: l2_we_i, data: l2_data_i};

  always_comb begin
    first    = lane1;
    first_v  = l1_valid_i;
    second   = lane2;
    second_v = l2_valid_i;
    if (order_change_i) begin
      first    = lane2;
      first_v  = l2_valid_i;
      second   = lane1;
      second_v = l1_valid_i;
    end
  end

  // Compact the valid lanes so pushed entries are contiguous at the write pointer.
  always_comb begin
    push0    = first;
    push1    = second;
    push_cnt = 2'd0;
    if (accept) begin
      if (first_v && second_v) begin
        push_cnt = 2'd2;
      end else if (first_v) begin
        push_cnt = 2'd1;
      end else if (second_v) begin
        push0    = second;
        push_cnt = 2'd1;
      end
    end
  end

  assign c0_valid = (count != '0);
  assign c1_valid = (count >= CW'(2));
  assign pop_cnt  = commit_ready_i ? ({1'b0, c0_valid} + {1'b0, c1_valid}) : 2'd0;

  commit_fifo_2w #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_i    (rst_i),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (push1),
    .pop_cnt  (pop_cnt),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  assign c0 = force_fields(head0, c0_valid);
  assign c1 = force_fields(head1, c1_valid);

  assign c0_valid_o  = c0_valid;
  assign c0_pc_o     = c0.pc;
  assign c0_rd_o     = c0.rd;
  assign c0_we_o     = c0.we;
  assign c0_data_o   = c0.data;
  assign c1_valid_o  = c1_valid;
  assign c1_pc_o     = c1.pc;
  assign c1_rd_o     = c1.rd;
  assign c1_we_o     = c1.we;
  assign c1_data_o   = c1.data;
  assign occupancy_o = count;

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) retired_cnt_o <= '0;
    else       retired_cnt_o <= retired_cnt_o + 64'(pop_cnt);
  end
`endif

`ifndef SYNTHESIS
  a_push_needs_ready: assert property (@(posedge clk) disable iff (rst_i)
    (push_cnt != 2'd0) |-> in_ready_o);
`endif

endmodule

// File: tb/tb_wb_order_restorer.sv
// Scoreboard bench for wb_order_restorer: a program-order queue model fed at
// acceptance, and a negedge monitor comparing every presented commit slot.
module tb_wb_order_restorer;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int EW    = 70;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        order_change_i = 1'b0;
  logic        l1_valid_i = 1'b0;
  logic [31:0] l1_pc_i = '0;
  logic [4:0]  l1_rd_i = '0;
  logic        l1_we_i = 1'b0;
  logic [31:0] l1_data_i = '0;
  logic        l2_valid_i = 1'b0;
  logic [31:0] l2_pc_i = '0;
  logic [4:0]  l2_rd_i = '0;
  logic        l2_we_i = 1'b0;
  logic [31:0] l2_data_i = '0;
  logic        c0_valid_o, c1_valid_o, c0_we_o, c1_we_o;
  logic [31:0] c0_pc_o, c0_data_o, c1_pc_o, c1_data_o;
  logic [4:0]  c0_rd_o, c1_rd_o;
  logic        commit_ready_i = 1'b0;
  logic [3:0]  occupancy_o;
`ifdef RETIRE_CNT_EN
  logic [63:0] retired_cnt_o;
  logic [63:0] exp_retired = '0;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic exp_ready = 1'b1;
  logic relief = 1'b0;

  wb_order_restorer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .order_change_i(order_change_i),
    .l1_valid_i(l1_valid_i), .l1_pc_i(l1_pc_i), .l1_rd_i(l1_rd_i), .l1_we_i(l1_we_i), .l1_data_i(l1_data_i),
    .l2_valid_i(l2_valid_i), .l2_pc_i(l2_pc_i), .l2_rd_i(l2_rd_i), .l2_we_i(l2_we_i), .l2_data_i(l2_data_i),
    .c0_valid_o(c0_valid_o), .c0_pc_o(c0_pc_o), .c0_rd_o(c0_rd_o), .c0_we_o(c0_we_o), .c0_data_o(c0_data_o),
    .c1_valid_o(c1_valid_o), .c1_pc_o(c1_pc_o), .c1_rd_o(c1_rd_o), .c1_we_o(c1_we_o), .c1_data_o(c1_data_o),
    .commit_ready_i(commit_ready_i), .occupancy_o(occupancy_o)
`ifdef RETIRE_CNT_EN
    , .retired_cnt_o(retired_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // A committed instruction never writes x0.
  function automatic logic [EW-1:0] mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic we, input logic [31:0] data);
    return {pc, rd, we && (rd != 5'd0), data};
  endfunction

  // ---------------- reference model: program-order queue ----------------
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      exp_q.delete();
`ifdef RETIRE_CNT_EN
      exp_retired = '0;
`endif
    end else if (in_valid_i && exp_ready) begin
      if (!order_change_i) begin
        if (l1_valid_i) exp_q.push_back(mk(l1_pc_i, l1_rd_i, l1_we_i, l1_data_i));
        if (l2_valid_i) exp_q.push_back(mk(l2_pc_i, l2_rd_i, l2_we_i, l2_data_i));
      end else begin
        if (l2_valid_i) exp_q.push_back(mk(l2_pc_i, l2_rd_i, l2_we_i, l2_data_i));
        if (l1_valid_i) exp_q.push_back(mk(l1_pc_i, l1_rd_i, l1_we_i, l1_data_i));
      end
    end
  end

  // ---------------- monitor ----------------
  int n;
  logic [EW-1:0] e0, e1;
  always @(negedge clk) begin
    n  = exp_q.size();
    e0 = (n >= 1) ? exp_q[0] : '0;
    e1 = (n >= 2) ? exp_q[1] : '0;
    check("in_ready", EW'(in_ready_o), EW'((DEPTH - n) >= 2));
    check("occupancy", EW'(occupancy_o), EW'(n));
    check("c0_valid", EW'(c0_valid_o), EW'(n >= 1));
    check("c1_valid", EW'(c1_valid_o), EW'(n >= 2));
    check("c0_fields", {c0_pc_o, c0_rd_o, c0_we_o, c0_data_o}, e0);
    check("c1_fields", {c1_pc_o, c1_rd_o, c1_we_o, c1_data_o}, e1);
`ifdef RETIRE_CNT_EN
    check("retired_cnt", EW'(retired_cnt_o), EW'(exp_retired));
`endif
    exp_ready = ((DEPTH - n) >= 2);
    if (commit_ready_i && !rst_i) begin
      for (int k = 0; k < 2; k++) begin
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
`ifdef RETIRE_CNT_EN
          exp_retired = exp_retired + 64'd1;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    cycles(1);
    rst_i = 1'b0;
  endtask

  task automatic send(input logic oc,
                      input logic v1, input logic [31:0] pc1, input logic [4:0] rd1,
                      input logic we1, input logic [31:0] d1,
                      input logic v2, input logic [31:0] pc2, input logic [4:0] rd2,
                      input logic we2, input logic [31:0] d2);
    int w;
    order_change_i = oc;
    l1_valid_i = v1; l1_pc_i = pc1; l1_rd_i = rd1; l1_we_i = we1; l1_data_i = d1;
    l2_valid_i = v2; l2_pc_i = pc2; l2_rd_i = rd2; l2_we_i = we2; l2_data_i = d2;
    in_valid_i = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready_o) break;
      w++;
      if (w > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=in_ready_o low for %0d cycles required=accept", w);
        break;
      end
      @(posedge clk);
      #1;
      if (relief && w >= 4) commit_ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    l1_valid_i = 1'b0;
    l2_valid_i = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] pc_a, input logic [4:0] rd_a);
    send(1'b0, 1'b1, pc_a, rd_a, 1'b1, $urandom, 1'b1, pc_a + 32'd4, rd_a + 5'd1, 1'b1, $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cycles(3);
    rst_i = 1'b0;
    cycles(1);

    // In-order and swapped pairs must both commit 0x10 then 0x14.
    commit_ready_i = 1'b1;
    send(1'b0, 1'b1, 32'h10, 5'd5, 1'b1, $urandom, 1'b1, 32'h14, 5'd6, 1'b1, $urandom);
    cycles(3);
    send(1'b1, 1'b1, 32'h14, 5'd6, 1'b1, $urandom, 1'b1, 32'h10, 5'd5, 1'b1, $urandom);
    cycles(3);

    // Single-lane replay, then a normal pair.
    send(1'b1, 1'b1, 32'h20, 5'd7, 1'b1, $urandom, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    send(1'b0, 1'b1, 32'h24, 5'd8, 1'b1, $urandom, 1'b1, 32'h28, 5'd9, 1'b0, $urandom);
    cycles(3);

    // Fill to DEPTH under backpressure, then release and stream across the wrap.
    commit_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(32'h100 + 32'(i * 8), 5'(2 * i + 1));
    cycles(2);
    check("full_occupancy", EW'(occupancy_o), EW'(DEPTH));
    check("full_in_ready", EW'(in_ready_o), EW'(0));
    commit_ready_i = 1'b1;
    cycles(6);
    for (int i = 0; i < 10; i++) send_pair(32'h400 + 32'(i * 8), 5'(i + 3));
    cycles(3);

    // Lane 2 targets x0 with we=1: write suppressed, data still shown.
    send(1'b0, 1'b1, 32'h200, 5'd3, 1'b1, $urandom, 1'b1, 32'h204, 5'd0, 1'b1, 32'hdeadbeef);
    cycles(3);

    // Both lanes invalid: accepted, nothing buffered.
    send(1'b0, 1'b0, 32'h300, 5'd1, 1'b1, 32'h1, 1'b0, 32'h304, 5'd2, 1'b1, 32'h2);
    cycles(2);

    // Mid-operation reset with five entries buffered.
    commit_ready_i = 1'b0;
    send_pair(32'h500, 5'd10);
    send_pair(32'h508, 5'd12);
    send(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h510, 5'd14, 1'b1, $urandom);
    cycles(1);
    check("pre_reset_occupancy", EW'(occupancy_o), EW'(5));
    pulse_reset();
    @(negedge clk);
    check("post_reset_occupancy", EW'(occupancy_o), EW'(0));
    check("post_reset_c0_valid", EW'(c0_valid_o), EW'(0));
    check("post_reset_in_ready", EW'(in_ready_o), EW'(1));
`ifdef RETIRE_CNT_EN
    check("post_reset_retired", EW'(retired_cnt_o), EW'(0));
`endif
    @(posedge clk);
    #1;
    commit_ready_i = 1'b1;
    cycles(3);

    // Randomized traffic with random consumer stalls.
    relief = 1'b1;
    for (int i = 0; i < 300; i++) begin
      commit_ready_i = ($urandom_range(0, 3) != 0);
      send(1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) != 0), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 5) != 0), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 4) == 0) cycles(1);
    end
    commit_ready_i = 1'b1;
    cycles(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
